jpeg_izigzag_buffer: RTL



---
 rtl/jpeg_izigzag_buffer.sv | 95 +++++++++
 1 files changed

// File: rtl/jpeg_izigzag_buffer.sv
// Inverse zig-zag ping-pong buffer: zig-zag ordered coefficients in, raster-ordered out.
// Define JPEG_IZIGZAG_TRANSPOSE_EN to read each block out in column-major order.
module jpeg_izigzag_buffer #(
   parameter int DWIDTH = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [DWIDTH-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [DWIDTH-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dout_sob,
   output logic              dout_eob
);

   // Zig-zag scan index -> raster index
   localparam logic [5:0] ZZ2R [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   logic [DWIDTH-1:0] mem [128];
   logic              wr_bank, rd_bank;
   logic [5:0]        wr_cnt, rd_cnt;
   logic [1:0]        full, full_nxt;
   logic              wr_xfer, wr_last, rd_load, rd_last;
   logic [5:0]        wr_addr, rd_addr;

   assign din_ready = !full[wr_bank];
   assign wr_xfer   = ena & din_valid & din_ready;
   assign wr_last   = wr_xfer & (wr_cnt == 6'd63);
   assign rd_load   = ena & full[rd_bank] & (!dout_valid | dout_ready);
   assign rd_last   = rd_load & (rd_cnt == 6'd63);
   assign wr_addr   = ZZ2R[wr_cnt];

`ifdef JPEG_IZIGZAG_TRANSPOSE_EN
   assign rd_addr = {rd_cnt[2:0], rd_cnt[5:3]};
`else
   assign rd_addr = rd_cnt;
`endif

   // Write side sets and read side clears always hit different banks, so both apply.
   always_comb begin
      // NOTE: default assignment first; without it some paths leave full_nxt unassigned and a latch is inferred.
      full_nxt = full;
      if (wr_last) full_nxt[wr_bank] = 1'b1;
      if (rd_last) full_nxt[rd_bank] = 1'b0;
   end

   // NOTE: coefficient storage is deliberately not reset; the full flags alone decide what is readable.
   always_ff @(posedge clk) begin
      if (wr_xfer) mem[{wr_bank, wr_addr}] <= din;
   end

   // NOTE: non-blocking assignments for all registered state so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         full       <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_sob   <= 1'b0;
         dout_eob   <= 1'b0;
      end else if (ena) begin
         full <= full_nxt;
         if (wr_xfer) begin
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_last) wr_bank <= ~wr_bank;
         end
         if (rd_load) begin
            dout       <= mem[{rd_bank, rd_addr}];
            dout_sob   <= (rd_cnt == 6'd0);
            dout_eob   <= (rd_cnt == 6'd63);
            dout_valid <= 1'b1;
            rd_cnt     <= rd_cnt + 6'd1;
            if (rd_last) rd_bank <= ~rd_bank;
         end else if (dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule
